// File: rtl/xcorr_peak_pick.sv
// rtl/xcorr_peak_pick.sv - peak picker over one frame of cross-correlation results
// Define XCORR_PEAK_ABS_EN to rank samples by magnitude instead of signed value.
module xcorr_peak_pick #(
    parameter int RES_W  = 32,
    parameter int LAG_W  = 6,
    parameter int N_LAGS = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             complete,
    input  logic [RES_W-1:0] result,
    output logic [LAG_W-1:0] lag_diff,
    output logic [RES_W-1:0] peak_val,
    output logic             busy,
    output logic             done
);

    localparam int K_W = $clog2(N_LAGS + 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(N_LAGS - 1);
    localparam logic [LAG_W-1:0] HALF   = LAG_W'((N_LAGS - 1) / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                  state;
    logic                    armed;
    logic [K_W-1:0]          k;
    logic [K_W-1:0]          k_peak;
    logic signed [RES_W-1:0] max_key;
    logic [RES_W-1:0]        max_val;
    logic signed [RES_W-1:0] key;

    // Ranking key: the signed sample, or its magnitude with the most-negative
    // code saturated so it cannot wrap back to a negative number.
    always_comb begin
        key = result;
`ifdef XCORR_PEAK_ABS_EN
        if (result[RES_W-1]) begin
            if (result == {1'b1, {(RES_W-1){1'b0}}})
                key = {1'b0, {(RES_W-1){1'b1}}};
            else
                key = -result;
        end
`endif
    end

    // armed remembers that start was high, so a frame only opens on a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            k        <= '0;
            k_peak   <= '0;
            max_key  <= '0;
            max_val  <= '0;
            lag_diff <= '0;
            peak_val <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state   <= S_IDLE;
                armed   <= 1'b1;
                k       <= '0;
                k_peak  <= '0;
                max_key <= '0;
                max_val <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (armed) begin
                            state <= S_COLLECT;
                            armed <= 1'b0;
                            busy  <= 1'b1;
                            k     <= '0;
                        end
                    end
                    S_COLLECT: begin
                        if (complete) begin
                            if (k == '0 || key > max_key) begin
                                max_key <= key;
                                max_val <= result;
                                k_peak  <= k;
                            end
                            if (k == K_LAST) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                            end else begin
                                k <= k + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        lag_diff <= LAG_W'(k_peak) - HALF;
                        peak_val <= max_val;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                        k        <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xcorr_peak_pick.sv
// tb/tb_xcorr_peak_pick.sv - directed table-driven bench for xcorr_peak_pick
module tb_xcorr_peak_pick;

`ifdef XCORR_PEAK_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        complete = 1'b0;
    logic [31:0] result = '0;
    logic [5:0]  lag_diff;
    logic [31:0] peak_val;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    xcorr_peak_pick #(.RES_W(32), .LAG_W(6), .N_LAGS(63)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .complete (complete),
        .result   (result),
        .lag_diff (lag_diff),
        .peak_val (peak_val),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    typedef struct {
        bit ramp;
        int base;
        int pk;
        int pv;
        int tk;
        int tv;
        int lag;
        int val;
        int lag_a;
        int val_a;
        bit gaps;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int res_of(input vec_t v, input int k);
        if (v.ramp) return k;
        if (k == v.pk) return v.pv;
        if (k == v.tk) return v.tv;
        return v.base;
    endfunction

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("busy_after_arm", busy, 1);
    endtask

    task automatic send(input int val);
        complete = 1'b1;
        result = val;
        tick();
        complete = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int d0;
        d0 = done_cnt;
        arm();
        for (int k = 0; k < 63; k++) begin
            if (v.gaps && k > 0) repeat ($urandom_range(0, 3)) tick();
            send(res_of(v, k));
        end
        chk({tag, "_done_lat1"}, done, 0);
        tick();
        chk({tag, "_done_lat2"}, done, 1);
        chk({tag, "_lag"}, $signed(lag_diff), ABS ? v.lag_a : v.lag);
        chk({tag, "_val"}, $signed(peak_val), ABS ? v.val_a : v.val);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        logic [5:0]  hold_lag;
        logic [31:0] hold_val;

        //                ramp base   pk  pv            tk  tv            lag  val           lag_a val_a         gaps
        vecs[0] = '{1'b1, 0,     0,  0,            63, 0,            31,  62,           31,   62,           1'b0};
        vecs[1] = '{1'b0, -1000, 10, 500,          40, 500,          -21, 500,          -31,  -1000,        1'b0};
        vecs[2] = '{1'b0, 0,     62, 7,            63, 0,            31,  7,            31,   7,            1'b0};
        vecs[3] = '{1'b0, 5,     0,  100,          63, 0,            -31, 100,          -31,  100,          1'b1};
        vecs[4] = '{1'b0, -5,    31, -1,           63, 0,            0,   -1,           -31,  -5,           1'b0};
        vecs[5] = '{1'b0, 123,   0,  123,          63, 0,            -31, 123,          -31,  123,          1'b1};
        vecs[6] = '{1'b0, 0,     50, -9000,        20, 8000,         -11, 8000,         19,   -9000,        1'b0};
        vecs[7] = '{1'b0, 0,     40, 32'h80000000, 45, 32'h7FFFFFFF, 14,  32'h7FFFFFFF, 9,    32'h80000000, 1'b0};

        #12;
        chk("rst_lag", lag_diff, 0);
        chk("rst_val", peak_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        repeat (3) tick();
        chk("no_frame_without_start", busy, 0);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // extra completes after a frame must be ignored and outputs must hold
        d0 = done_cnt;
        hold_lag = lag_diff;
        hold_val = peak_val;
        for (int i = 0; i < 5; i++) send(1000 + i);
        repeat (3) tick();
        chk("extra_no_done", done_cnt - d0, 0);
        chk("extra_busy", busy, 0);
        chk("extra_hold_lag", lag_diff, hold_lag);
        chk("extra_hold_val", peak_val, hold_val);

        // abort after 30 results, then a clean frame with peak at k=31
        d0 = done_cnt;
        arm();
        for (int k = 0; k < 30; k++) send(5000 + k);
        start = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        start = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_hold_lag", lag_diff, hold_lag);
        chk("abort_hold_val", peak_val, hold_val);
        begin
            vec_t v;
            v = '{1'b0, 1, 31, 99, 63, 0, 0, 99, 0, 99, 1'b0};
            run_frame(v, "post_abort");
        end

        // asynchronous reset mid-frame clears outputs without a done
        d0 = done_cnt;
        arm();
        for (int k = 0; k < 20; k++) send(k);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lag", lag_diff, 0);
        chk("mid_rst_val", peak_val, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) send(k);
        chk("post_rst_idle", busy, 0);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        run_frame(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
